// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops and a word_size-cycle shift-add multiplier,
// with a valid/ready handshake on both sides and registered result and flags.
module seq_alu #(
    parameter int word_size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [word_size-1:0] R2,
    input  logic [word_size-1:0] R3,
    input  logic [2:0]           ALUOp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [word_size-1:0] R1,
    output logic                 zero,
    output logic                 neg
);

    localparam int CNT_W = $clog2(word_size) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(word_size - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                 state_q, state_d;
    logic [word_size-1:0]   r1_q, r1_d;
    logic                   zero_q, zero_d;
    logic                   neg_q, neg_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic [word_size-1:0]   acc_q, acc_d;
    logic [word_size-1:0]   mcand_q, mcand_d;
    logic [word_size-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   load_r1;
    logic [word_size-1:0]   load_val;

    function automatic logic [word_size-1:0] alu_result(
        input logic [2:0]           op,
        input logic [word_size-1:0] a,
        input logic [word_size-1:0] b
    );
        logic signed [word_size-1:0] sa;
        logic signed [word_size-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0:    alu_result = a;
            3'd1:    alu_result = ~a;
            3'd2:    alu_result = a + b;
            3'd3:    alu_result = a - b;
            3'd4:    alu_result = a | b;
            3'd5:    alu_result = a & b;
            3'd6:    alu_result = (sa < sb) ? {{(word_size-1){1'b0}}, 1'b1} : '0;
            default: alu_result = '0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        load_r1  = 1'b0;
        load_val = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (ALUOp == 3'd7) begin
                        mcand_d  = R2;
                        mplier_d = R3;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        load_r1  = 1'b1;
                        load_val = alu_result(ALUOp, R2, R3);
                        state_d  = DONE;
                    end
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Fixed iteration count: no early exit even when the multiplier runs out of ones.
                if (cnt_q == CNT_LAST) begin
                    load_r1  = 1'b1;
                    load_val = acc_d;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        r1_d        = load_r1 ? load_val : r1_q;
        zero_d      = load_r1 ? (load_val == '0) : zero_q;
        neg_d       = load_r1 ? load_val[word_size-1] : neg_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r1_q        <= '0;
            zero_q      <= 1'b1;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    // Operand shift registers carry no control meaning, so they are left out of reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

    assign R1        = r1_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (word_size = 32): expected results are queued at issue time
// and popped when the result appears.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] R2;
    logic [W-1:0] R3;
    logic [2:0]   ALUOp;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R1;
    logic         zero;
    logic         neg;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    longint unsigned t_accept;

    seq_alu #(.word_size(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .R2(R2), .R3(R3), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
        .R1(R1), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [63:0] p;
        case (op)
            3'd0: return a;
            3'd1: return ~a;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return a | b;
            3'd5: return a & b;
            3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
        endcase
    endfunction

    // Presents one operation while the DUT is idle; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        ALUOp    = op;
        R2       = a;
        R3       = b;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        t_accept = $time;
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counted in edges, the accepting edge being the first.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        ALUOp = 3'd2; R2 = 32'd1; R3 = 32'd1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        checks++;
        if ({R1, zero, neg, out_valid, in_ready} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: R1=%h zero=%b neg=%b ov=%b ir=%b, need 0 1 0 0 1",
                     R1, zero, neg, out_valid, in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [W-1:0] e;
        send(3'd2, 32'd5, 32'd7);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d need 1", lat); end
        checks++;
        if ({R1, zero, neg, in_ready} !== {e, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add: R1=%h zero=%b neg=%b ir=%b, need %h 0 0 0", R1, zero, neg, in_ready, e);
        end
        take();
        checks++;
        if ({out_valid, in_ready, R1} !== {1'b0, 1'b1, 32'd12}) begin
            errors++;
            $display("FAIL add_handoff: ov=%b ir=%b R1=%h, need 0 1 0000000c", out_valid, in_ready, R1);
        end
    endtask

    task automatic test_ops();
        int lat;
        logic [W-1:0] e;
        logic [2:0]   ops[3] = '{3'd3, 3'd6, 3'd2};
        logic [W-1:0] as[3]  = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] bs[3]  = '{32'd3, 32'd1, 32'd1};
        for (int i = 0; i < 3; i++) begin
            send(ops[i], as[i], bs[i]);
            wait_out(lat);
            e = exp_q.pop_front();
            checks++;
            if ({R1, zero, neg} !== {e, e == 0, e[W-1]}) begin
                errors++;
                $display("FAIL op%0d_fixed: R1=%h zero=%b neg=%b need %h", ops[i], R1, zero, neg, e);
            end
            take();
        end
        for (int i = 0; i < 14; i++) begin
            logic [2:0] op;
            logic [W-1:0] a, b;
            op = 3'(i % 7);
            a = $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            send(op, a, b);
            wait_out(lat);
            e = exp_q.pop_front();
            checks++;
            if ({lat, R1, zero, neg} !== {32'd1, e, e == 0, e[W-1]}) begin
                errors++;
                $display("FAIL op%0d_rand: lat=%0d R1=%h zero=%b neg=%b need 1 %h", op, lat, R1, zero, neg, e);
            end
            take();
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [W-1:0] e;
        logic [W-1:0] as[4] = '{32'h0001_0003, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0};
        logic [W-1:0] bs[4] = '{32'd5, 32'hFFFF_FFFF, 32'h0000_0003, 32'h1234_5678};
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a, b;
            a = (i < 4) ? as[i] : $urandom;
            b = (i < 4) ? bs[i] : $urandom;
            send(3'd7, a, b);
            wait_out(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== W + 1) begin errors++; $display("FAIL mul_latency%0d: got %0d need %0d", i, lat, W + 1); end
            checks++;
            if ({R1, zero, neg} !== {e, e == 0, e[W-1]}) begin
                errors++;
                $display("FAIL mul%0d: R1=%h zero=%b neg=%b need %h", i, R1, zero, neg, e);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] e;
        send(3'd3, 32'd1, 32'd2);
        wait_out(lat);
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            ALUOp = 3'(i);
            R2 = $urandom;
            R3 = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, R1, neg} !== {1'b1, 1'b0, e, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b R1=%h neg=%b need 1 0 %h 1", i, out_valid, in_ready, R1, neg, e);
            end
        end
        in_valid = 1'b0;
        take();
        checks++;
        if ({out_valid, in_ready, R1} !== {1'b0, 1'b1, e}) begin
            errors++;
            $display("FAIL bp_release: ov=%b ir=%b R1=%h need 0 1 %h", out_valid, in_ready, R1, e);
        end
        take();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL idle_out_ready: ov=%b ir=%b need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] e;
        longint unsigned prev;
        for (int i = 0; i < 5; i++) begin
            logic [2:0] op;
            op = (i == 2) ? 3'd7 : 3'(i);
            prev = t_accept;
            send(op, $urandom, $urandom);
            if (i > 0) begin
                checks++;
                if ((t_accept - prev) / 10 !== ((i == 3) ? W + 2 : 2)) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles need %0d", i, (t_accept - prev) / 10,
                             (i == 3) ? W + 2 : 2);
                end
            end
            wait_out(lat);
            e = exp_q.pop_front();
            checks++;
            if (R1 !== e) begin errors++; $display("FAIL b2b%0d: R1=%h need %h", i, R1, e); end
            take();
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0;
        send(3'd7, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        checks++;
        if ({R1, zero, neg, out_valid, in_ready} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_mul_reset: R1=%h zero=%b neg=%b ov=%b ir=%b need 0 1 0 0 1",
                     R1, zero, neg, out_valid, in_ready);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_mul_no_output: out_valid seen %0d need 0", seen); end
        send(3'd1, 32'h0F0F_0F0F, 32'd0);
        begin
            int lat;
            wait_out(lat);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        checks++;
        if ({R1, zero, out_valid, in_ready} !== {32'd0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL done_reset: R1=%h zero=%b ov=%b ir=%b need 0 1 0 1", R1, zero, out_valid, in_ready);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b0;
        ALUOp = '0;
        R2 = '0;
        R3 = '0;
        rst_n = 1'b0;
        t_accept = 0;
        @(negedge clk);
        test_reset();
        test_add();
        test_ops();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: word_size, default 32, operand/result width in bits; legal values 2..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  operands and opcode presented this cycle.
REQ-005 Port: in_ready  output  1  block can accept an operation this cycle.
REQ-006 Port: R2  input  word_size  first operand.
REQ-007 Port: R3  input  word_size  second operand.
REQ-008 Port: ALUOp  input  3  opcode.
REQ-009 Port: out_valid  output  1  R1 and flags hold a completed result.
REQ-010 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port: R1  output  word_size  registered result.
REQ-012 Port: zero  output  1  registered; 1 when R1 == 0.
REQ-013 Port: neg  output  1  registered; copy of R1[word_size-1].

Function
REQ-014 The block SHALL decode ALUOp as: 0 R2; 1 ~R2; 2 R2+R3; 3 R2-R3; 4 R2|R3; 5 R2&R3; 6 signed(R2)<signed(R3) ? 1 : 0 (zero-extended); 7 unsigned R2*R3, low word_size bits.
REQ-015 Add, subtract and multiply SHALL wrap modulo 2^word_size; no carry or overflow output.
REQ-016 The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-017 in_ready SHALL be 1 in IDLE only; in_valid SHALL be ignored in MUL and DONE.
REQ-018 Accept = in_valid && in_ready at a rising edge; operands and opcode SHALL be sampled only then.
REQ-019 IDLE, accept, ALUOp 0..6: R1/zero/neg SHALL load the result at that edge; next state DONE (latency 1 cycle).
REQ-020 IDLE, accept, ALUOp 7: operands SHALL be latched, accumulator cleared, iteration counter cleared; next state MUL.
REQ-021 MUL SHALL perform one shift-add step per cycle: if multiplier LSB=1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-022 After word_size MUL cycles, the final accumulator SHALL load R1/zero/neg and the state SHALL become DONE; accept-to-out_valid latency = word_size+1 cycles.
REQ-023 MUL SHALL take exactly word_size cycles regardless of operand values (no early termination).
REQ-024 DONE: out_valid=1; on out_ready=1, next state IDLE; otherwise remain in DONE.
REQ-025 R1, zero, neg SHALL remain stable from entering DONE until the next result load; they are not cleared on handoff.
REQ-026 out_valid SHALL be 0 in IDLE and MUL.
REQ-027 Maximum throughput: one ALU operation per 2 cycles; one multiply per word_size+2 cycles.
REQ-028 out_ready asserted outside DONE SHALL have no effect.
REQ-029 The iteration counter SHALL be clog2(word_size)+1 bits wide, so the terminal count word_size cannot wrap.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force state IDLE, R1=0, zero=1, neg=0, out_valid=0, in_ready=1, counter=0, accumulator=0, in any state including mid-MUL and DONE.
REQ-031 Reset SHALL take precedence over accept and out_ready in the same cycle; an in-flight operation is discarded and produces no output.

Verification
REQ-032 Reset: hold rst_n=0 for 2 cycles -> R1=0, zero=1, neg=0, out_valid=0, in_ready=1.
REQ-033 Add: R2=5, R3=7, ALUOp=2, in_valid pulse -> next cycle out_valid=1, R1=12, zero=0, neg=0; in_ready=0 until out_ready handshake.
REQ-034 Sub/SLT: R2=3, R3=3, op 3 -> R1=0, zero=1; then R2=0xFFFFFFFF, R3=1, op 6 -> R1=1; op 2 on 0xFFFFFFFF+1 -> R1=0, zero=1.
REQ-035 Multiply (word_size=32): R2=0x00010003, R3=5, op 7 -> out_valid exactly 33 cycles after accept, R1=0x0005000F; R2=0xFFFFFFFF, R3=0xFFFFFFFF -> R1=1.
REQ-036 Backpressure: result in DONE, out_ready=0 for 4 cycles with in_valid=1 and changing operands -> R1 and out_valid unchanged, no new accept; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-MUL: rst_n=0 for one cycle 10 cycles after multiply accept -> IDLE, R1=0, out_valid never asserted for that operation.
